// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared types and defaults for the pattern transmitter.
//   state_e      - FSM state encoding (StPar exists only with PATTERN_TX_PARITY_EN)
//   PatWDefault  - default frame width in bits
//   CntWDefault  - default width of the repeat count
// Optional feature macro: PATTERN_TX_PARITY_EN (appends an even-parity bit to each frame).
package pattern_tx_pkg;

  localparam int unsigned PatWDefault = 4;
  localparam int unsigned CntWDefault = 4;

`ifdef PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: request/serial-output bundle of the pattern transmitter.
//   start_i      - transfer request (sampled by the transmitter only when idle)
//   pattern_i    - frame bits, sent MSB first
//   repeat_i     - number of extra frames (frames sent = repeat_i + 1)
//   dout_o       - serial data bit
//   dout_valid_o - dout_o carries a frame or parity bit
//   busy_o       - transfer in progress
//   done_o       - one-cycle pulse after the last bit
// master: the requester; slave: the transmitter.
interface pattern_tx_if
  import pattern_tx_pkg::*;
#(
  parameter int unsigned PAT_W = PatWDefault,
  parameter int unsigned CNT_W = CntWDefault
);

  logic             start_i;
  logic [PAT_W-1:0] pattern_i;
  logic [CNT_W-1:0] repeat_i;
  logic             dout_o;
  logic             dout_valid_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, pattern_i, repeat_i,
    input  dout_o, dout_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, pattern_i, repeat_i,
    output dout_o, dout_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/pattern_shift_reg.sv
// pattern_shift_reg: latched frame plus bit index for MSB-first serialisation.
//   clk, rst    - clock, asynchronous active-high reset
//   load_i      - latch pattern_i and point at the MSB
//   step_i      - move to the next lower bit
//   rewind_i    - point back at the MSB of the latched frame
//   pattern_i   - frame to latch
//   last_o      - index is at the LSB
//   next_bit_o  - bit that becomes current after a step
//   msb_o       - MSB of the latched frame
//   parity_o    - even parity of the latched frame (only with PATTERN_TX_PARITY_EN)
module pattern_shift_reg #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             rewind_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             last_o,
  output logic             next_bit_o,
`ifdef PATTERN_TX_PARITY_EN
  output logic             parity_o,
`endif
  output logic             msb_o
);

  localparam int unsigned IdxW = $clog2(PAT_W);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(PAT_W - 1);

  logic [PAT_W-1:0] frame_q, frame_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  idx_m1;

  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    if (load_i) begin
      frame_d = pattern_i;
      idx_d   = IdxMax;
    end else if (rewind_i) begin
      idx_d   = IdxMax;
    end else if (step_i) begin
      idx_d   = idx_q - IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_m1     = idx_q - IdxW'(1);
  assign last_o     = (idx_q == '0);
  // At the LSB the look-ahead index wraps; the bit is unused there, so force 0.
  assign next_bit_o = last_o ? 1'b0 : frame_q[idx_m1];
  assign msb_o      = frame_q[PAT_W-1];
`ifdef PATTERN_TX_PARITY_EN
  assign parity_o   = ^frame_q;
`endif

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serialises a PAT_W-bit pattern MSB first, repeat+1 frames back to back.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - pattern_tx_if slave: start/pattern/repeat in, dout/dout_valid/busy/done out
// All outputs are registered; first bit appears the cycle after start is accepted.
// Optional feature macro: PATTERN_TX_PARITY_EN inserts an even-parity bit after each frame.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int unsigned PAT_W = PatWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic         clk,
  input  logic         rst,
  pattern_tx_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             frame_end;

  logic sr_load, sr_step, sr_rewind;
  logic sr_last, sr_next_bit, sr_msb;
`ifdef PATTERN_TX_PARITY_EN
  logic sr_parity;
`endif

  pattern_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sr_load),
    .step_i     (sr_step),
    .rewind_i   (sr_rewind),
    .pattern_i  (bus.pattern_i),
    .last_o     (sr_last),
    .next_bit_o (sr_next_bit),
`ifdef PATTERN_TX_PARITY_EN
    .parity_o   (sr_parity),
`endif
    .msb_o      (sr_msb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    frame_end = 1'b0;
    sr_load   = 1'b0;
    sr_step   = 1'b0;
    sr_rewind = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          sr_load = 1'b1;
          cnt_d   = bus.repeat_i;
          dout_d  = bus.pattern_i[PAT_W-1];
          valid_d = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!sr_last) begin
          sr_step = 1'b1;
          dout_d  = sr_next_bit;
          valid_d = 1'b1;
        end else begin
`ifdef PATTERN_TX_PARITY_EN
          dout_d  = sr_parity;
          valid_d = 1'b1;
          state_d = StPar;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      StPar: frame_end = 1'b1;
`endif
      default: state_d = StIdle;
    endcase

    // Either start the next frame back to back or finish the transfer.
    if (frame_end) begin
      if (cnt_q != '0) begin
        cnt_d     = cnt_q - CNT_W'(1);
        sr_rewind = 1'b1;
        dout_d    = sr_msb;
        valid_d   = 1'b1;
        state_d   = StShift;
      end else begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout_o       = dout_q;
  assign bus.dout_valid_o = valid_q;
  // busy spans exactly the cycles that carry a bit, so it shares the valid flop.
  assign bus.busy_o       = valid_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed self-checking bench for pattern_tx (PAT_W=4, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pattern_tx;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  pattern_tx_if #(.PAT_W(4), .CNT_W(4)) bus_if ();

  pattern_tx #(
    .PAT_W (4),
    .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check_eq({tag, "_valid"}, 64'(bus_if.dout_valid_o), 64'd0);
    check_eq({tag, "_busy"},  64'(bus_if.busy_o),       64'd0);
    check_eq({tag, "_dout"},  64'(bus_if.dout_o),       64'd0);
    check_eq({tag, "_done"},  64'(bus_if.done_o),       64'(exp_done));
  endtask

  task automatic check_bit(input string tag, input logic exp_bit);
    check_eq({tag, "_valid"}, 64'(bus_if.dout_valid_o), 64'd1);
    check_eq({tag, "_busy"},  64'(bus_if.busy_o),       64'd1);
    check_eq({tag, "_done"},  64'(bus_if.done_o),       64'd0);
    check_eq({tag, "_dout"},  64'(bus_if.dout_o),       64'(exp_bit));
  endtask

  // Start a transfer now (cycle 0); expect n bits exp[n-1:0] MSB first, then done.
  task automatic send_and_check(input string tag, input logic [3:0] pat, input logic [3:0] rpt,
                                input logic [63:0] exp, input int n);
    bus_if.pattern_i = pat;
    bus_if.repeat_i  = rpt;
    bus_if.start_i   = 1'b1;
    tick();
    bus_if.start_i   = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_bit($sformatf("%s_b%0d", tag, i), exp[n-1-i]);
      tick();
    end
    check_idle({tag, "_end"}, 1'b1);
    tick();
    check_idle({tag, "_post"}, 1'b0);
  endtask

  initial begin
    int dones;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus_if.start_i   = 1'b0;
    bus_if.pattern_i = 4'b0000;
    bus_if.repeat_i  = 4'd0;
    tick();
    tick();
    check_idle("reset", 1'b0);
    rst = 1'b0;
    tick();
    check_idle("after_rst", 1'b0);

`ifdef PATTERN_TX_PARITY_EN
    // 1011 has odd weight -> parity bit 1 after each frame.
    send_and_check("par", 4'b1011, 4'd1, 64'b1011110111, 10);
`else
    // Single frame 1010.
    send_and_check("basic", 4'b1010, 4'd0, 64'b1010, 4);

    // Three frames back to back.
    send_and_check("rep2", 4'b1100, 4'd2, 64'b110011001100, 12);

    // start with a new pattern during a transfer is ignored and not queued.
    bus_if.pattern_i = 4'b1010;
    bus_if.repeat_i  = 4'd0;
    bus_if.start_i   = 1'b1;
    tick();
    bus_if.start_i   = 1'b0;
    check_bit("ign_b0", 1'b1);
    tick();
    bus_if.start_i   = 1'b1;
    bus_if.pattern_i = 4'b0001;
    bus_if.repeat_i  = 4'd3;
    check_bit("ign_b1", 1'b0);
    tick();
    bus_if.start_i   = 1'b0;
    check_bit("ign_b2", 1'b1);
    tick();
    check_bit("ign_b3", 1'b0);
    tick();
    check_idle("ign_end", 1'b1);
    dones = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_if.done_o) dones++;
      check_eq($sformatf("ign_quiet%0d", i), 64'(bus_if.dout_valid_o), 64'd0);
    end
    check_eq("ign_dones", 64'(dones), 64'd1);

    // Reset in the middle of a frame abandons it without a done pulse.
    bus_if.pattern_i = 4'b1010;
    bus_if.repeat_i  = 4'd0;
    bus_if.start_i   = 1'b1;
    tick();
    bus_if.start_i   = 1'b0;
    check_bit("rst_b0", 1'b1);
    tick();
    check_bit("rst_b1", 1'b0);
    tick();
    check_bit("rst_b2", 1'b1);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_async", 1'b0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_if.done_o) dones++;
    end
    check_eq("rst_no_done", 64'(dones), 64'd0);
    check_idle("rst_idle", 1'b0);
    send_and_check("rst_again", 4'b1010, 4'd0, 64'b1010, 4);

    // start held through the done cycle; pattern change while busy is ignored,
    // and the second transfer picks up the pattern present in the done cycle.
    bus_if.pattern_i = 4'b1010;
    bus_if.repeat_i  = 4'd0;
    bus_if.start_i   = 1'b1;
    tick();
    bus_if.pattern_i = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      check_bit($sformatf("hold1_b%0d", i), (i % 2) == 0);
      tick();
    end
    check_idle("hold_done", 1'b1);
    tick();
    bus_if.start_i = 1'b0;
    check_bit("hold2_b0", 1'b0);
    tick();
    check_bit("hold2_b1", 1'b1);
    tick();
    check_bit("hold2_b2", 1'b1);
    tick();
    check_bit("hold2_b3", 1'b0);
    tick();
    check_idle("hold2_end", 1'b1);
    tick();

    // Maximum repeat: 16 frames, counter must not wrap.
    send_and_check("maxrep", 4'b1001, 4'd15, {16{4'b1001}}, 64);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4: bits per frame, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 4: width of the repeat input.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to transmit; sampled only in IDLE.
REQ-006 SHALL have port pattern, input, PAT_W: frame bits, sent MSB first; latched on start acceptance.
REQ-007 SHALL have port repeat, input, CNT_W: frames sent = repeat+1; latched on start acceptance.
REQ-008 SHALL have port dout, input-to-line serial output, output, 1: current serial bit, registered.
REQ-009 SHALL have port dout_valid, output, 1: dout carries a frame or parity bit this cycle.
REQ-010 SHALL have port busy, output, 1: high from the cycle after acceptance through the last transmitted bit.
REQ-011 SHALL have port done, output, 1: single-cycle pulse in the cycle after the last bit.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, PAR (PAR present only per REQ-024).
REQ-013 IDLE with start=1 at an edge SHALL latch pattern/repeat, load bit index PAT_W-1, and load frame counter=repeat; in the next cycle dout=pattern[PAT_W-1], dout_valid=1, busy=1, state SHIFT (latency 1 cycle).
REQ-014 SHIFT with bit index>0 SHALL decrement the index and present the next lower bit; one bit per clock, no gaps.
REQ-015 SHIFT with bit index=0 and frame counter>0 SHALL decrement the counter and restart at the MSB next cycle (frames back-to-back).
REQ-016 SHIFT with bit index=0 and frame counter=0 SHALL go to IDLE; next cycle dout=0, dout_valid=0, busy=0, done=1.
REQ-017 A start received while busy=1 SHALL be ignored, with no queuing; pattern/repeat changes while busy SHALL have no effect.
REQ-018 A start in the done cycle SHALL be accepted (state is IDLE); first bit of the new transfer follows in the next cycle.
REQ-019 done SHALL be high for exactly one cycle per transfer; done and dout_valid SHALL never both be high.
REQ-020 A transfer SHALL last exactly (repeat+1)*PAT_W valid cycles (plus parity cycles per REQ-024).
REQ-021 Counters SHALL NOT wrap: repeat=2^CNT_W-1 yields 2^CNT_W frames.

Reset
REQ-022 rst=1 SHALL force IDLE immediately; dout=0, dout_valid=0, busy=0, done=0; latched pattern/counters cleared.
REQ-023 rst asserted mid-frame SHALL abandon the transfer with no done pulse; the first start after release SHALL begin a fresh transfer.

Configuration
REQ-024 With PATTERN_TX_PARITY_EN defined, after each frame's LSB the FSM SHALL enter PAR for one cycle, driving dout=even parity (XOR) of the latched pattern with dout_valid=1, then continue per REQ-015/REQ-016.
REQ-025 Without PATTERN_TX_PARITY_EN, the PAR state and parity logic SHALL be absent; timing is exactly per REQ-013..REQ-020.

Structure
REQ-026 Package pattern_tx_pkg SHALL hold the state enum (IDLE, SHIFT, PAR) and the default PAT_W/CNT_W constants.
REQ-027 The shift/bit-index datapath SHALL be sub-module pattern_shift_reg (load, shift, index==0 flag); FSM and frame counter SHALL reside in pattern_tx.

Verification
REQ-028 pattern=1010, repeat=0, start at cycle 0 -> dout 1,0,1,0 at cycles 1-4 with dout_valid=1; done=1 and busy=0 at cycle 5.
REQ-029 pattern=1100, repeat=2 -> 12 contiguous valid bits 110011001100; single done pulse at cycle 13.
REQ-030 start pulsed with pattern=0001 at cycle 2 during a 1010 transfer -> output unchanged 1010, one done pulse only.
REQ-031 rst asserted at cycle 3 of a 1010 transfer -> dout_valid/busy=0 immediately, no done; start after release -> full 1010 from MSB.
REQ-032 start held high through done cycle with repeat=0 -> second transfer begins the cycle after done with no idle gap beyond it.
REQ-033 PATTERN_TX_PARITY_EN defined, pattern=1011, repeat=1 -> 1,0,1,1,1,1,0,1,1,1 valid (parity 1 after each frame); done at cycle 11.
